// File: rtl/pipelined_or_csg.sv
// rtl/pipelined_or_csg.sv - two-stage registered OR-merge of per-block iteration values
// Stage 1 forms per-group partial ORs and a valid popcount; stage 2 folds the groups into out.
module pipelined_or_csg #(
    parameter int MAX_NO_OF_PROGRAM_BLOCKS = 12,
    parameter int ITERATION_VARIABLE_WIDTH = 16,
    parameter int REDUCE_MODE              = 0,
    parameter int HOLD_LAST                = 1,
    parameter int GROUP_SIZE               = 4
) (
    input  logic                                                     clk,
    input  logic                                                     rst_n,
    input  logic [MAX_NO_OF_PROGRAM_BLOCKS*ITERATION_VARIABLE_WIDTH-1:0] in,
    input  logic [MAX_NO_OF_PROGRAM_BLOCKS-1:0]                      in_valid,
    input  logic                                                     en,
    input  logic                                                     clr_err,
    output logic [ITERATION_VARIABLE_WIDTH-1:0]                      out,
    output logic                                                     out_valid,
    output logic [$clog2(MAX_NO_OF_PROGRAM_BLOCKS+1)-1:0]            active_count,
    output logic                                                     multi_src
);

    localparam int N  = MAX_NO_OF_PROGRAM_BLOCKS;
    localparam int W  = ITERATION_VARIABLE_WIDTH;
    localparam int CW = $clog2(N + 1);
    localparam int NG = (N + GROUP_SIZE - 1) / GROUP_SIZE;

    logic [N-1:0]  w_mask;
    logic [W-1:0]  w_part [NG];
    logic [CW-1:0] w_cnt;
    logic [W-1:0]  w_merge;

    logic [W-1:0]  r_part [NG];
    logic          r_s1_valid;
    logic [CW-1:0] r_s1_cnt;
    logic [W-1:0]  r_out;
    logic          r_out_valid;
    logic [CW-1:0] r_active_count;
    logic          r_multi_src;

    // In merge-all mode every lane contributes data; in_valid only drives valid/count.
    assign w_mask = (REDUCE_MODE == 1) ? in_valid : {N{1'b1}};

    always_comb begin
        w_part = '{default: '0};
        w_cnt  = '0;
        for (int i = 0; i < N; i++) begin
            w_part[i / GROUP_SIZE] = w_part[i / GROUP_SIZE] | (in[i*W +: W] & {W{w_mask[i]}});
            w_cnt = w_cnt + CW'(in_valid[i]);
        end
    end

    always_comb begin
        w_merge = '0;
        for (int g = 0; g < NG; g++) begin
            w_merge = w_merge | r_part[g];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int g = 0; g < NG; g++) begin
                r_part[g] <= '0;
            end
            r_s1_valid     <= 1'b0;
            r_s1_cnt       <= '0;
            r_out          <= '0;
            r_out_valid    <= 1'b0;
            r_active_count <= '0;
            r_multi_src    <= 1'b0;
        end else begin
            if (en) begin
                r_part         <= w_part;
                r_s1_valid     <= |in_valid;
                r_s1_cnt       <= w_cnt;
                r_out_valid    <= r_s1_valid;
                r_active_count <= r_s1_cnt;
                if (r_s1_valid) begin
                    r_out <= w_merge;
                end else if (HOLD_LAST == 0) begin
                    r_out <= '0;
                end
            end
            // Detection is aligned with the sample entering stage 2; a fresh set beats a clear.
            if (en && (REDUCE_MODE == 1) && (r_s1_cnt > CW'(1))) begin
                r_multi_src <= 1'b1;
            end else if (clr_err) begin
                r_multi_src <= 1'b0;
            end
        end
    end

    assign out          = r_out;
    assign out_valid    = r_out_valid;
    assign active_count = r_active_count;
    assign multi_src    = r_multi_src;

endmodule

// File: tb/tb_pipelined_or_csg.sv
// tb/tb_pipelined_or_csg.sv - directed self-checking bench for pipelined_or_csg
// Three instances share stimulus: valid-only/hold, valid-only/force-zero, merge-all/hold.
module tb_pipelined_or_csg;

    localparam int N  = 12;
    localparam int W  = 16;
    localparam int CW = $clog2(N + 1);

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] vin;
    logic [N-1:0]   vld;
    logic           en;
    logic           clr_err;

    logic [W-1:0]  out_a, out_b, out_c;
    logic          ov_a, ov_b, ov_c;
    logic [CW-1:0] cnt_a, cnt_b, cnt_c;
    logic          ms_a, ms_b, ms_c;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipelined_or_csg #(.MAX_NO_OF_PROGRAM_BLOCKS(N), .ITERATION_VARIABLE_WIDTH(W),
                       .REDUCE_MODE(1), .HOLD_LAST(1), .GROUP_SIZE(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in(vin), .in_valid(vld), .en(en), .clr_err(clr_err),
        .out(out_a), .out_valid(ov_a), .active_count(cnt_a), .multi_src(ms_a));

    pipelined_or_csg #(.MAX_NO_OF_PROGRAM_BLOCKS(N), .ITERATION_VARIABLE_WIDTH(W),
                       .REDUCE_MODE(1), .HOLD_LAST(0), .GROUP_SIZE(4)) u_dut_h0 (
        .clk(clk), .rst_n(rst_n), .in(vin), .in_valid(vld), .en(en), .clr_err(clr_err),
        .out(out_b), .out_valid(ov_b), .active_count(cnt_b), .multi_src(ms_b));

    pipelined_or_csg #(.MAX_NO_OF_PROGRAM_BLOCKS(N), .ITERATION_VARIABLE_WIDTH(W),
                       .REDUCE_MODE(0), .HOLD_LAST(1), .GROUP_SIZE(4)) u_dut_m0 (
        .clk(clk), .rst_n(rst_n), .in(vin), .in_valid(vld), .en(en), .clr_err(clr_err),
        .out(out_c), .out_valid(ov_c), .active_count(cnt_c), .multi_src(ms_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        vin = '0;
        vld = '0;
    endtask

    task automatic set_lane(input int i, input logic [W-1:0] v, input logic valid);
        vin[i*W +: W] = v;
        vld[i]        = valid;
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b1;
        clr_err = 1'b0;
        vin     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        vld     = '1;
        repeat (3) step();
        check("rst_out",   32'(out_a), 32'h0);
        check("rst_valid", 32'(ov_a),  32'h0);
        check("rst_cnt",   32'(cnt_a), 32'h0);
        check("rst_multi", 32'(ms_a),  32'h0);
        check("rst_m0_out", 32'(out_c), 32'h0);

        // Sample A: two valid lanes
        rst_n = 1'b1;
        clear_in();
        set_lane(3, 16'h0010, 1'b1);
        set_lane(7, 16'h0100, 1'b1);
        step();
        check("lat1_valid", 32'(ov_a), 32'h0);

        // Sample B: single valid lane plus an invalid all-ones lane
        clear_in();
        set_lane(11, 16'hBEEF, 1'b1);
        set_lane(0,  16'hFFFF, 1'b0);
        step();
        check("a_out",   32'(out_a), 32'h0110);
        check("a_valid", 32'(ov_a),  32'h1);
        check("a_cnt",   32'(cnt_a), 32'h2);
        check("a_multi", 32'(ms_a),  32'h1);
        check("a_h0_out", 32'(out_b), 32'h0110);
        check("a_m0_out", 32'(out_c), 32'h0110);
        check("a_m0_multi", 32'(ms_c), 32'h0);

        // Sample C: lane5 valid, lane6 invalid
        clear_in();
        set_lane(5, 16'h1234, 1'b1);
        set_lane(6, 16'h0001, 1'b0);
        step();
        check("b_out",   32'(out_a), 32'hBEEF);
        check("b_cnt",   32'(cnt_a), 32'h1);
        check("b_multi", 32'(ms_a),  32'h1);
        check("b_m0_out", 32'(out_c), 32'hFFFF);

        // Stall for five edges with garbage inputs; clear the sticky flag on the last one
        en  = 1'b0;
        vin = '1;
        vld = '1;
        step();
        check("stall_out",   32'(out_a), 32'hBEEF);
        check("stall_valid", 32'(ov_a),  32'h1);
        repeat (3) step();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("stall5_out",   32'(out_a), 32'hBEEF);
        check("stall5_valid", 32'(ov_a),  32'h1);
        check("stall_clr",    32'(ms_a),  32'h0);

        // Sample D after the stall
        en = 1'b1;
        clear_in();
        set_lane(2, 16'h8000, 1'b1);
        step();
        check("c_out",    32'(out_a), 32'h1234);
        check("c_m0_out", 32'(out_c), 32'h1235);

        // Sample E: two valid lanes again
        clear_in();
        set_lane(3, 16'h0010, 1'b1);
        set_lane(7, 16'h0100, 1'b1);
        step();
        check("d_out", 32'(out_a), 32'h8000);
        check("d_cnt", 32'(cnt_a), 32'h1);

        // Idle input, clr_err on the same edge the 2-valid sample reaches stage 2
        clear_in();
        clr_err = 1'b1;
        step();
        check("e_out",        32'(out_a), 32'h0110);
        check("set_over_clr", 32'(ms_a),  32'h1);
        check("e_m0_multi",   32'(ms_c),  32'h0);

        step();
        check("clr_alone",   32'(ms_a),  32'h0);
        check("hold_out",    32'(out_a), 32'h0110);
        check("hold_valid",  32'(ov_a),  32'h0);
        check("hold_cnt",    32'(cnt_a), 32'h0);
        check("h0_out",      32'(out_b), 32'h0000);
        check("h0_valid",    32'(ov_b),  32'h0);

        clr_err = 1'b0;
        step();
        check("hold2_out", 32'(out_a), 32'h0110);
        check("m0_hold",   32'(out_c), 32'h0110);

        // Reset with a sample in flight
        set_lane(9, 16'h4242, 1'b1);
        step();
        rst_n = 1'b0;
        step();
        check("mid_rst_out",   32'(out_a), 32'h0);
        check("mid_rst_valid", 32'(ov_a),  32'h0);
        rst_n = 1'b1;
        clear_in();
        set_lane(4, 16'h0040, 1'b1);
        step();
        check("post_rst_lat1", 32'(ov_a), 32'h0);
        clear_in();
        step();
        check("post_rst_out",   32'(out_a), 32'h0040);
        check("post_rst_valid", 32'(ov_a),  32'h1);
        check("post_rst_cnt",   32'(cnt_a), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
